// File: rtl/rr_arb_4_1.sv
// rtl/rr_arb_4_1.sv - round-robin 4:1 arbiter with one-entry registered output buffer
module rr_arb_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic             load_ok;
  logic             accept;
  logic [WIDTH-1:0] win_data;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    case (win)
      2'd0:    win_data = d0;
      2'd1:    win_data = d1;
      2'd2:    win_data = d2;
      default: win_data = d3;
    endcase
  end

  assign out_valid = (state == FULL);
  assign load_ok   = !out_valid || out_ready;
  assign in_ready  = (!rst && load_ok && found) ? (4'b0001 << win) : 4'b0000;
  assign accept    = |in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= 2'd0;
      out_data <= '0;
      out_sel  <= 2'd0;
    end else if (accept) begin
      state    <= FULL;
      out_data <= win_data;
      out_sel  <= win;
      ptr      <= win + 2'd1;
    end else if (state == FULL && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_rr_arb_4_1.sv
// tb/tb_rr_arb_4_1.sv - randomized and directed checks of rr_arb_4_1 against a reference model
module tb_rr_arb_4_1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [3:0] d0, d1, d2, d3;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_sel;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int         m_ptr;
  bit         m_valid;
  logic [3:0] m_data;
  int         m_sel;

  rr_arb_4_1 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  function automatic int ref_grant(int p, logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] pick(int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    if (rst) return 4'b0;
    if (m_valid && !out_ready) return 4'b0;
    g = ref_grant(m_ptr, in_valid);
    if (g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    int g;
    bit lok;
    g   = ref_grant(m_ptr, in_valid);
    lok = !m_valid || out_ready;
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_data = 4'h0; m_sel = 0;
    end else if (lok && g >= 0) begin
      m_data = pick(g); m_sel = g; m_valid = 1; m_ptr = (g + 1) % 4;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic drive(logic r, logic [3:0] v, logic ordy);
    rst = r; in_valid = v; out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      drive(1'b1, 4'($urandom), 1'($urandom));
      tests++; if (in_ready !== 4'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      tests++; if (out_data !== 4'h0) begin fails++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      tests++; if (out_sel !== 2'd0) begin fails++; $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
    end
  endtask

  task automatic test_single();
    d0 = 4'h1; d1 = 4'h2; d2 = 4'hA; d3 = 4'h4;
    drive(1'b0, 4'b0100, 1'b1);
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL single_in_ready got=%b exp=0100", in_ready); end
    tick();
    drive(1'b0, 4'b0000, 1'b1);
    tests++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'hA) begin
      fails++; $display("FAIL single_out got v=%b sel=%0d data=%h exp v=1 sel=2 data=a", out_valid, out_sel, out_data);
    end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_rotation();
    drive(1'b1, 4'b0000, 1'b1);
    tick();
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 4'b1111, 1'b1);
      tests++; if (in_ready !== 4'(1 << (c % 4))) begin fails++; $display("FAIL rot_in_ready[%0d] got=%b exp=%b", c, in_ready, 4'(1 << (c % 4))); end
      tick();
      tests++; if (out_valid !== 1'b1 || out_sel !== 2'(c % 4) || out_data !== 4'(c % 4 + 1)) begin
        fails++; $display("FAIL rot_out[%0d] got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%0d", c, out_valid, out_sel, out_data, c % 4, c % 4 + 1);
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 4'b1001, 1'b1);
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL wrap_first got=%b exp=0001", in_ready); end
    tick();
    drive(1'b0, 4'b1001, 1'b1);
    tests++; if (in_ready !== 4'b1000) begin fails++; $display("FAIL wrap_second got=%b exp=1000", in_ready); end
    tick();
    tests++; if (out_sel !== 2'd3 || out_data !== 4'h4) begin fails++; $display("FAIL wrap_out got sel=%0d data=%h exp sel=3 data=4", out_sel, out_data); end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 4'b1111, 1'b0);
      tests++; if (in_ready !== 4'b0) begin fails++; $display("FAIL stall_in_ready[%0d] got=%b exp=0000", c, in_ready); end
      tick();
      tests++; if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 4'h4) begin
        fails++; $display("FAIL stall_hold[%0d] got v=%b sel=%0d data=%h exp v=1 sel=3 data=4", c, out_valid, out_sel, out_data);
      end
    end
    drive(1'b0, 4'b1111, 1'b1);
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL stall_release got=%b exp=0001", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'h1) begin
      fails++; $display("FAIL stall_reload got v=%b sel=%0d data=%h exp v=1 sel=0 data=1", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 4'b1111, 1'b0);
    tick();
    drive(1'b1, 4'b1111, 1'b1);
    tests++; if (in_ready !== 4'b0) begin fails++; $display("FAIL midrst_in_ready got=%b exp=0000", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 4'h0) begin
      fails++; $display("FAIL midrst_out got v=%b sel=%0d data=%h exp v=0 sel=0 data=0", out_valid, out_sel, out_data);
    end
    drive(1'b0, 4'b1111, 1'b1);
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL midrst_first got=%b exp=0001", in_ready); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] er;
    for (int c = 0; c < 300; c++) begin
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      drive(($urandom_range(0, 39) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
      er = exp_ready();
      tests++; if (in_ready !== er) begin fails++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", c, in_ready, er); end
      tick();
      tests++; if (out_valid !== m_valid || out_sel !== 2'(m_sel) || out_data !== m_data) begin
        fails++; $display("FAIL rand_out[%0d] got v=%b sel=%0d data=%h exp v=%b sel=%0d data=%h", c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
      end
    end
  endtask

  initial begin
    m_ptr = 0; m_valid = 0; m_data = 4'h0; m_sel = 0;
    rst = 1'b1; in_valid = 4'b0; out_ready = 1'b0;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
